// File: rtl/spi_master_shifter.sv
// ---------------------------------------------------------------------------
// spi_master_shifter
//
// Mode-0 (CPOL=0, CPHA=0) SPI master shift engine. SCLK is generated from a
// half-period counter running on clk_in, so the whole block is single-clock.
// One DATA_WIDTH word is accepted per start request, shifted out MSB-first on
// mosi while miso is captured MSB-first, and the received word is presented
// on rx_data together with a one-cycle done pulse.
//
// Parameters:
//   CLK_DIV    clk_in cycles per SCLK half-period (>= 1)
//   DATA_WIDTH bits per transfer (>= 2)
//
// Ports:
//   clk_in   system clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   start    transfer request, only looked at while idle
//   tx_data  word to send, captured on the accepting edge
//   busy     high from the cycle after acceptance until done
//   done     single-cycle end-of-transfer pulse
//   rx_data  last received word, held until the next done
//   sclk     SPI clock, idles low
//   mosi     SPI data out
//   miso     SPI data in, assumed synchronous to clk_in
//   cs_n     active-low chip select
// ---------------------------------------------------------------------------
module spi_master_shifter #(
    parameter int CLK_DIV    = 50,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_ALL  = BIT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      half_q, half_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_d;
    logic                  sclk_d;
    logic                  mosi_d;
    logic                  cs_n_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  half_end;

    // The half-period counter reaching its last value marks the end of
    // every timed phase: CS setup, each SCLK half-period and CS hold.
    assign half_end = (half_q == HALF_LAST);

    // Next-state and next-output logic. Everything defaults to holding its
    // value, except done which is a pulse and therefore defaults low.
    // Sampling miso in the same step that raises sclk gives mode-0 capture
    // on the rising edge as seen by the slave. On a falling half-period the
    // next bit is presented until all bits have gone out; the falling edge
    // after the last bit moves on to the CS hold phase with mosi unchanged.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data;
        sclk_d     = sclk;
        mosi_d     = mosi;
        cs_n_d     = cs_n;
        busy_d     = busy;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[DATA_WIDTH-1];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    half_d     = '0;
                    bit_d      = '0;
                    state_d    = LEAD;
                end
            end

            LEAD: begin
                if (half_end) begin
                    half_d  = '0;
                    state_d = SHIFT;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            SHIFT: begin
                if (half_end) begin
                    half_d = '0;
                    sclk_d = ~sclk;
                    if (!sclk) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                        bit_d      = bit_q + 1'b1;
                    end else if (bit_q < BITS_ALL) begin
                        tx_shift_d = tx_shift_q << 1;
                        mosi_d     = tx_shift_q[DATA_WIDTH-2];
                    end else begin
                        state_d = TRAIL;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            TRAIL: begin
                if (half_end) begin
                    half_d    = '0;
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    state_d   = IDLE;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over any transfer in
    // progress: the bus returns to idle and no done pulse is produced.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            half_q     <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data    <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data    <= rx_data_d;
            sclk       <= sclk_d;
            mosi       <= mosi_d;
            cs_n       <= cs_n_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: doc/spi_master_shifter.md
Name: spi_master_shifter

Overview:
- Mode-0 SPI master shift engine (CPOL=0, CPHA=0) for the SPI master driver.
- Sits downstream of the system clock divider stage and consumes the same fast system clock.
- Generates SCLK internally from a half-period counter, so the core stays single-clock.
- Accepts one DATA_WIDTH word per start request, sends it MSB-first on MOSI, captures MISO, and returns the received word with a one-cycle done pulse.

Parameters:
- CLK_DIV, 50: clk_in cycles per SCLK half-period. Must be ≥1. An SCLK period is 2*CLK_DIV clk_in cycles.
- DATA_WIDTH, 8: bits per transfer. Must be ≥2.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  transfer request; sampled only when busy=0.
- tx_data  input  DATA_WIDTH  word to send; latched on the accepting edge.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  single-cycle pulse at end of transfer.
- rx_data  output  DATA_WIDTH  last received word; valid from the done cycle and held until the next done.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in; treated as synchronous to clk_in.
- cs_n  output  1  chip select, active-low.

Behaviour:
- Reset values (the cycle after rst is sampled high): busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=1, FSM=IDLE, all counters=0.
- rst overrides everything, including mid-transfer. No done pulse is produced and rx_data is cleared.
- IDLE state:
  - On an edge with start=1: latch tx_data into tx_shift, drive cs_n=0, mosi=tx_data[DATA_WIDTH-1], busy=1, load half-period counter, go to LEAD.
  - start while busy=1 is ignored; it is not queued.
- LEAD state: hold sclk=0 for CLK_DIV cycles (CS setup time), then go to SHIFT.
- SHIFT state:
  - Every CLK_DIV cycles sclk toggles. Total of 2*DATA_WIDTH toggles.
  - Rising toggle: on the same clk_in edge that sets sclk=1, shift miso into the rx_shift LSB (MSB-first capture). Increment bit count.
  - Falling toggle: if bits sent < DATA_WIDTH, advance tx_shift and drive the next bit on mosi. After the final (DATA_WIDTH-th) falling toggle, mosi holds the last bit. Go to TRAIL.
- TRAIL state: hold sclk=0 for CLK_DIV cycles (CS hold time). On the final edge, do all of the following in the same cycle, then return to IDLE:
  - cs_n=1, mosi=0, busy=0
  - done=1 for exactly one cycle
  - rx_data=rx_shift
- Timing:
  - With start accepted at edge 0, cs_n is low for exactly CLK_DIV*(2*DATA_WIDTH+2) cycles.
  - done is high in the first cycle cs_n is high again.
  - First sclk rise occurs 2*CLK_DIV cycles after acceptance.
- Back-to-back transfers: start asserted in the done cycle is accepted (busy=0), and cs_n goes low again the next cycle. Minimum cs_n high time is therefore 1 cycle.
- Counters:
  - Half-period counter width is clog2(CLK_DIV)+1, wraps to 0 at CLK_DIV-1.
  - Bit counter width is clog2(DATA_WIDTH)+1.
- CLK_DIV=1: sclk toggles every cycle. Same sequencing, no special case.
- tx_data changes after acceptance have no effect on the transfer in progress.

Test Plan:
- Loopback: mosi wired to miso, CLK_DIV=2, DATA_WIDTH=8, tx_data=0xA5 → mosi bit sequence 1,0,1,0,0,1,0,1 on sclk rises; rx_data=0xA5 at done; done high exactly 1 cycle.
- Timing: CLK_DIV=2, DATA_WIDTH=8 → cs_n low exactly 36 cycles; 8 sclk rising edges; first rise 4 cycles after the start edge; sclk period 4 cycles.
- miso held 1, tx_data=0x00 → rx_data=0xFF and mosi constantly 0 while cs_n=0. Then miso held 0 → rx_data=0x00.
- start pulsed again at bit 3 of an active transfer → ignored; only one done and one cs_n low window. start asserted in the done cycle → second transfer begins, cs_n high for 1 cycle.
- rst asserted after the 4th sclk rise → next cycle sclk=0, cs_n=1, busy=0, mosi=0, rx_data=0, no done. A subsequent start with 0x3C transfers correctly.
- CLK_DIV=1, DATA_WIDTH=16, loopback with 0xBEEF → rx_data=0xBEEF; cs_n low 34 cycles.
